// File: rtl/knn_pkg.sv
// Shared types for the KNN query scheduler: FSM state encoding and default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package knn_pkg;

    localparam int DEF_FEAT_W  = 7;
    localparam int DEF_LABEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/knn_rr_arb.sv
// Round-robin picker: first requester with req set, searching upward from ptr_i with wrap.
// Latency: purely combinational; the pointer register lives in the caller.
// Backpressure: none; gnt_o is all-zero when no request is pending.
module knn_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    int   cand;
    logic found;

    // Walk the requesters starting at the pointer and take the first one asserted.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/knn_query_scheduler.sv
// Shares one KNN core among NUM_REQ requesters; optional watchdog under KNN_SCHED_TIMEOUT_EN.
// Latency: gnt -> core_start 1 cycle, gnt -> rsp_valid 3 cycles minimum (done on first WAIT cycle).
// Backpressure: one query in flight; req is only sampled in IDLE and must be held until gnt.
module knn_query_scheduler
    import knn_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int FEAT_W      = DEF_FEAT_W,
    parameter int LABEL_W     = DEF_LABEL_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*FEAT_W-1:0] req_unknown,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [LABEL_W-1:0]        rsp_label,
    output logic                      rsp_err,
    output logic                      core_start,
    output logic [FEAT_W:0]           core_unknown,
    input  logic                      core_done,
    input  logic [LABEL_W-1:0]        core_label,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FEAT_W-1:0]  feat_q, feat_d;
    logic [LABEL_W-1:0] label_q, label_d;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;

`ifdef KNN_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

    knn_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // Next-state: grant in IDLE, one issue cycle, wait for the core (or watchdog), one response cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        feat_d  = feat_q;
        label_d = label_q;
`ifdef KNN_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ISSUE;
                    idx_d   = arb_idx;
                    feat_d  = req_unknown[int'(arb_idx)*FEAT_W +: FEAT_W];
                    ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef KNN_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // A done arriving on the watchdog's last cycle still delivers the real label.
                if (core_done) begin
                    state_d = RESP;
                    label_d = core_label;
`ifdef KNN_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
`ifdef KNN_SCHED_TIMEOUT_EN
                else if (timeout) begin
                    state_d = RESP;
                    label_d = '1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any query in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            feat_q  <= '0;
            label_q <= '0;
`ifdef KNN_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            feat_q  <= feat_d;
            label_q <= label_d;
`ifdef KNN_SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // gnt is gated by rst so a held request cannot show a grant while reset is asserted.
    assign gnt          = (state_q == IDLE && !rst) ? arb_gnt : '0;
    assign core_start   = (state_q == ISSUE);
    assign core_unknown = {1'b0, feat_q};
    assign rsp_valid    = (state_q == RESP) ? (NUM_REQ'(1) << idx_q) : '0;
    assign rsp_label    = (state_q == RESP) ? label_q : '0;
    assign busy         = (state_q != IDLE);
`ifdef KNN_SCHED_TIMEOUT_EN
    assign rsp_err      = (state_q == RESP) && err_q;
`else
    assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_knn_query_scheduler.sv
// Testbench for knn_query_scheduler: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the scheduler.
module tb_knn_query_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int FEAT_W      = 7;
    localparam int LABEL_W     = 2;
    localparam int TIMEOUT_CYC = 16;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*FEAT_W-1:0] req_unknown = '0;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [LABEL_W-1:0]        rsp_label;
    logic                      rsp_err;
    logic                      core_start;
    logic [FEAT_W:0]           core_unknown;
    logic                      core_done = 1'b0;
    logic [LABEL_W-1:0]        core_label = '0;
    logic                      busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit auto_core = 1'b0;
    int lat_left  = -1;

    knn_query_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .FEAT_W      (FEAT_W),
        .LABEL_W     (LABEL_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_unknown  (req_unknown),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_label    (rsp_label),
        .rsp_err      (rsp_err),
        .core_start   (core_start),
        .core_unknown (core_unknown),
        .core_done    (core_done),
        .core_label   (core_label),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // Round-robin rule: first asserted requester after the last one granted, wrapping.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (last + k) % NUM_REQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- transaction-level model ----------------
    bit               m_active = 1'b0;   // a query has been accepted and not yet answered
    bit               m_issue  = 1'b0;   // this is the cycle right after acceptance
    bit               m_resp   = 1'b0;   // this is the answer cycle
    int               m_owner  = 0;
    int               m_last   = NUM_REQ - 1;
    int               m_wait   = 0;      // cycles spent waiting for the core
    logic [FEAT_W:0]  m_unk    = '0;
    logic [LABEL_W-1:0] m_label = '0;
    logic             m_err    = 1'b0;

    always @(posedge clk or posedge rst) begin
        int w;
        if (rst) begin
            m_active <= 1'b0;
            m_issue  <= 1'b0;
            m_resp   <= 1'b0;
            m_last   <= NUM_REQ - 1;
            m_wait   <= 0;
            m_unk    <= '0;
        end else if (!m_active) begin
            w = rr_pick(req, m_last);
            if (w >= 0) begin
                m_active <= 1'b1;
                m_issue  <= 1'b1;
                m_owner  <= w;
                m_last   <= w;
                m_unk    <= {1'b0, req_unknown[w*FEAT_W +: FEAT_W]};
            end
        end else if (m_resp) begin
            m_active <= 1'b0;
            m_resp   <= 1'b0;
        end else if (m_issue) begin
            m_issue <= 1'b0;
            m_wait  <= 0;
        end else if (core_done) begin
            m_label <= core_label;
            m_err   <= 1'b0;
            m_resp  <= 1'b1;
        end
`ifdef KNN_SCHED_TIMEOUT_EN
        else if (m_wait == TIMEOUT_CYC - 1) begin
            m_label <= '1;
            m_err   <= 1'b1;
            m_resp  <= 1'b1;
        end
`endif
        else begin
            m_wait <= m_wait + 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic [NUM_REQ-1:0] eg;
        int w;
        eg = '0;
        if (!rst && !m_active) begin
            w = rr_pick(req, m_last);
            if (w >= 0) eg[w] = 1'b1;
        end
        check("gnt", gnt, eg);
        check("busy", busy, m_active);
        check("core_start", core_start, m_active && m_issue);
        check("core_unknown", core_unknown, m_unk);
        check("rsp_valid", rsp_valid, m_resp ? (4'b0001 << m_owner) : 4'b0000);
        if (m_resp) begin
            check("rsp_label", rsp_label, m_label);
            check("rsp_err", rsp_err, m_err);
        end
    end

    // One clock cycle; also plays the role of the shared core when auto_core is set.
    task automatic tick();
        @(posedge clk);
        #1;
        core_done = 1'b0;
        if (auto_core) begin
            if (core_start) begin
                lat_left = $urandom_range(0, 5);
            end else if (lat_left == 0) begin
                core_done  = 1'b1;
                core_label = LABEL_W'($urandom);
                lat_left   = -1;
            end else if (lat_left > 0) begin
                lat_left--;
            end else if (!busy && $urandom_range(0, 7) == 0) begin
                core_done  = 1'b1;
                core_label = LABEL_W'($urandom);
            end
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && busy; c++) tick();
        #1 check("drain_idle", busy, 1'b0);
    endtask

    initial begin
        int got[5];
        int exp_order[5];
        logic [NUM_REQ-1:0] g;
        exp_order = '{0, 1, 2, 3, 0};
        got       = '{-1, -1, -1, -1, -1};

        // Reset state
        tick();
        tick();
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_core_unknown", core_unknown, 8'h00);
        check("rst_rsp_valid", rsp_valid, 4'b0000);
        check("rst_core_start", core_start, 1'b0);
        req = 4'hF;
        #1 check("rst_gnt_held_req", gnt, 4'b0000);
        req = '0;
        rst = 1'b0;

        // Single request from requester 2
        tick();
        req_unknown = (NUM_REQ*FEAT_W)'($urandom);
        req_unknown[2*FEAT_W +: FEAT_W] = 7'h2A;
        req = 4'b0100;
        #1 check("single_gnt", gnt, 4'b0100);
        tick();
        req = '0;
        req_unknown = (NUM_REQ*FEAT_W)'($urandom);
        #1;
        check("single_core_start", core_start, 1'b1);
        check("single_core_unknown", core_unknown, 8'h2A);
        tick();
        core_done  = 1'b1;
        core_label = 2'b01;
        #1 check("single_no_early_rsp", rsp_valid, 4'b0000);
        tick();
        #1;
        check("single_rsp_valid", rsp_valid, 4'b0100);
        check("single_rsp_label", rsp_label, 2'b01);
        check("single_rsp_err", rsp_err, 1'b0);
        tick();
        #1 check("single_back_idle", busy, 1'b0);

        // Spurious done in IDLE
        core_done = 1'b1;
        tick();
        #1 check("spurious_busy", busy, 1'b0);
        tick();
        #1 check("spurious_no_rsp", rsp_valid, 4'b0000);

        // Fairness with all requesters held high
        reset_pulse();
        req = 4'hF;
        auto_core = 1'b1;
        for (int c = 0, n = 0; c < 200 && n < 5; c++) begin
            #1;
            if (gnt != '0) begin
                got[n] = $clog2(gnt);
                n++;
            end
            tick();
        end
        for (int i = 0; i < 5; i++) check("fair_order", got[i], exp_order[i]);
        req = '0;
        drain();
        auto_core = 1'b0;
        lat_left  = -1;

        // Reset in the middle of WAIT; the last grant was 0 so requester 1 wins next
        tick();
        req = 4'b0010;
        #1 check("rstmid_gnt", gnt, 4'b0010);
        tick();
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_no_rsp", rsp_valid, 4'b0000);
        tick();
        rst = 1'b0;
        tick();
        core_done = 1'b1;
        tick();
        #1;
        check("rstmid_late_done_rsp", rsp_valid, 4'b0000);
        check("rstmid_late_done_busy", busy, 1'b0);
        req = 4'hF;
        #1 check("rstmid_next_gnt", gnt, 4'b0001);
        tick();
        req = '0;
        tick();
        core_done = 1'b1;
        core_label = 2'b11;
        tick();
        #1 check("rstmid_rsp", rsp_valid, 4'b0001);
        tick();

`ifdef KNN_SCHED_TIMEOUT_EN
        // Watchdog fires 16 cycles after entering WAIT
        req = 4'b1000;
        #1 check("to_gnt", gnt, 4'b1000);
        tick();
        req = '0;
        tick();
        for (int k = 1; k < 16; k++) tick();
        #1 check("to_not_early", rsp_valid, 4'b0000);
        tick();
        #1;
        check("to_rsp_valid", rsp_valid, 4'b1000);
        check("to_rsp_err", rsp_err, 1'b1);
        check("to_rsp_label", rsp_label, 2'b11);
        tick();
        #1 check("to_back_idle", busy, 1'b0);

        // Done on the watchdog's last cycle wins
        req = 4'b0001;
        #1 check("tie_gnt", gnt, 4'b0001);
        tick();
        req = '0;
        tick();
        for (int k = 1; k < 16; k++) tick();
        core_done  = 1'b1;
        core_label = 2'b10;
        tick();
        #1;
        check("tie_rsp_valid", rsp_valid, 4'b0001);
        check("tie_rsp_err", rsp_err, 1'b0);
        check("tie_rsp_label", rsp_label, 2'b10);
        tick();
`else
        // Without the watchdog the scheduler waits as long as the core needs
        req = 4'b1000;
        #1 check("nowd_gnt", gnt, 4'b1000);
        tick();
        req = '0;
        tick();
        for (int k = 0; k < 40; k++) tick();
        #1;
        check("nowd_still_busy", busy, 1'b1);
        check("nowd_no_rsp", rsp_valid, 4'b0000);
        core_done  = 1'b1;
        core_label = 2'b10;
        tick();
        #1;
        check("nowd_rsp_valid", rsp_valid, 4'b1000);
        check("nowd_rsp_err", rsp_err, 1'b0);
        check("nowd_rsp_label", rsp_label, 2'b10);
        tick();
`endif

        // Randomized traffic
        auto_core = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            #1 g = gnt;
            tick();
            rst = ($urandom_range(0, 399) == 0);
            req_unknown = (NUM_REQ*FEAT_W)'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (g[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                end
            end
        end
        rst = 1'b0;
        req = '0;
        drain();
        auto_core = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
